// File: rtl/int_logic_fu.sv
// Scoreboard-controlled 16-bit bitwise logic unit (AND/OR/XOR/NOT) with issue, execute and write-back stages.
// Optional: define INT_LOGIC_FU_STATS_EN to add the ops_done completion counter port.
module int_logic_fu #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [1:0]       issue_op,
  input  logic [WIDTH-1:0] issue_a,
  input  logic [WIDTH-1:0] issue_b,
  input  logic [TAG_W-1:0] issue_dest,
  output logic             fu_busy,
  output logic             wr_req,
  input  logic             wr_grant,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] result_dest
`ifdef INT_LOGIC_FU_STATS_EN
  ,
  output logic [15:0]      ops_done
`endif
);

  localparam int CNT_W = 4;  // covers the full 1..15 latency range

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    WAIT_WR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [TAG_W-1:0]   dest_q, dest_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               wr_req_q, wr_req_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [TAG_W-1:0]   result_dest_q, result_dest_d;

  function automatic logic [WIDTH-1:0] logic_fn(input op_e op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    unique case (op)
      OP_AND:  logic_fn = a & b;
      OP_OR:   logic_fn = a | b;
      OP_XOR:  logic_fn = a ^ b;
      default: logic_fn = ~a;
    endcase
  endfunction

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    dest_d        = dest_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    wr_req_d      = wr_req_q;
    result_d      = result_q;
    result_dest_d = result_dest_q;

    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          op_d    = op_e'(issue_op);
          a_d     = issue_a;
          b_d     = issue_b;
          dest_d  = issue_dest;
          cnt_d   = CNT_W'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d      = logic_fn(op_q, a_q, b_q);
          result_dest_d = dest_q;
          wr_req_d      = 1'b1;
          state_d       = WAIT_WR;
        end
      end
      WAIT_WR: begin
        // Issue attempts here are dropped because busy is still high this cycle.
        if (wr_grant) begin
          wr_req_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the operand holding registers are reset too, so an aborted instruction leaves no stale data.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= OP_AND;
      a_q           <= '0;
      b_q           <= '0;
      dest_q        <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      wr_req_q      <= 1'b0;
      result_q      <= '0;
      result_dest_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      dest_q        <= dest_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      wr_req_q      <= wr_req_d;
      result_q      <= result_d;
      result_dest_q <= result_dest_d;
    end
  end

  assign fu_busy     = busy_q;
  assign wr_req      = wr_req_q;
  assign result      = result_q;
  assign result_dest = result_dest_q;

`ifdef INT_LOGIC_FU_STATS_EN
  logic [15:0] ops_done_q, ops_done_d;

  // Counts retirements; wraps silently at 16 bits.
  always_comb begin
    ops_done_d = ops_done_q;
    if (state_q == WAIT_WR && wr_grant) ops_done_d = ops_done_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ops_done_q <= '0;
    else        ops_done_q <= ops_done_d;
  end

  assign ops_done = ops_done_q;
`endif

endmodule

// File: tb/tb_int_logic_fu.sv
// Self-checking bench for int_logic_fu: timestamp-based reference model checked every cycle plus directed literals.
module tb_int_logic_fu;

  localparam int WIDTH   = 16;
  localparam int LATENCY = 2;
  localparam int TAG_W   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_valid = 1'b0;
  logic [1:0]       issue_op = '0;
  logic [WIDTH-1:0] issue_a = '0;
  logic [WIDTH-1:0] issue_b = '0;
  logic [TAG_W-1:0] issue_dest = '0;
  logic             fu_busy;
  logic             wr_req;
  logic             wr_grant = 1'b0;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] result_dest;
`ifdef INT_LOGIC_FU_STATS_EN
  logic [15:0]      ops_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_logic_fu #(.WIDTH(WIDTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .issue_dest  (issue_dest),
    .fu_busy     (fu_busy),
    .wr_req      (wr_req),
    .wr_grant    (wr_grant),
    .result      (result),
    .result_dest (result_dest)
`ifdef INT_LOGIC_FU_STATS_EN
    ,
    .ops_done    (ops_done)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted instruction finishes at edge index (accept edge + LATENCY).
  function automatic logic [WIDTH-1:0] ref_fn(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  longint           edge_idx;
  longint           m_done_at;
  logic             m_busy, m_pending, m_wr_req;
  logic [WIDTH-1:0] m_pres, m_res;
  logic [TAG_W-1:0] m_pdest, m_dest;
  logic [15:0]      m_ops;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_idx  <= 0;
      m_done_at <= 0;
      m_busy    <= 1'b0;
      m_pending <= 1'b0;
      m_wr_req  <= 1'b0;
      m_pres    <= '0;
      m_res     <= '0;
      m_pdest   <= '0;
      m_dest    <= '0;
      m_ops     <= '0;
    end else begin
      edge_idx <= edge_idx + 1;
      if (!m_busy) begin
        if (issue_valid) begin
          m_busy    <= 1'b1;
          m_pending <= 1'b1;
          m_done_at <= edge_idx + LATENCY;
          m_pres    <= ref_fn(issue_op, issue_a, issue_b);
          m_pdest   <= issue_dest;
        end
      end else if (m_pending) begin
        if (edge_idx == m_done_at) begin
          m_pending <= 1'b0;
          m_wr_req  <= 1'b1;
          m_res     <= m_pres;
          m_dest    <= m_pdest;
        end
      end else if (m_wr_req && wr_grant) begin
        m_wr_req <= 1'b0;
        m_busy   <= 1'b0;
        m_ops    <= m_ops + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    check("fu_busy", fu_busy, m_busy);
    check("wr_req", wr_req, m_wr_req);
    check("result", result, m_res);
    check("result_dest", result_dest, m_dest);
`ifdef INT_LOGIC_FU_STATS_EN
    check("ops_done", ops_done, m_ops);
`endif
  end

  // Presents one instruction for one edge; returns at the negedge after that edge.
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] dest);
    @(negedge clk);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_dest  = dest;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic wait_wr_req();
    int n = 0;
    while (!wr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_req_timeout", wr_req, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fu_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_timeout", fu_busy, 1'b0);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[4] = '{
    '{2'b00, 16'h0008, 16'h0006, 16'h0000},
    '{2'b01, 16'h0008, 16'h0006, 16'h000E},
    '{2'b11, 16'h0008, 16'h1234, 16'hFFF7},
    '{2'b00, 16'hFFFF, 16'h00FF, 16'h00FF}
  };

  initial begin
    int n;
    // Reset state
    #12;
    check("rst_busy", fu_busy, 1'b0);
    check("rst_wr_req", wr_req, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_dest", result_dest, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // XOR 8^6 with grant tied high: wr_req two edges after accept
    wr_grant = 1'b1;
    issue(2'b10, 16'd8, 16'd6, 5'd3);
    check("xor_busy_e0", fu_busy, 1'b1);
    check("xor_req_e0", wr_req, 1'b0);
    @(negedge clk);
    check("xor_req_e1", wr_req, 1'b0);
    @(negedge clk);
    check("xor_req_e2", wr_req, 1'b1);
    check("xor_result", result, 16'd14);
    check("xor_dest", result_dest, 5'd3);
    @(negedge clk);
    check("xor_req_after_grant", wr_req, 1'b0);
    check("xor_busy_after_grant", fu_busy, 1'b0);

    // Directed table with immediate grant
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 4));
      wait_wr_req();
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_dest", i), result_dest, 5'(i + 4));
      wait_idle();
    end

    // Write-back stall with an ignored issue in the middle
    wr_grant = 1'b0;
    issue(2'b10, 16'h00F0, 16'h0FF0, 5'd9);
    wait_wr_req();
    for (int k = 0; k < 5; k++) begin
      issue_valid = (k == 2);
      issue_op    = 2'b01;
      issue_a     = 16'd1;
      issue_b     = 16'd2;
      issue_dest  = 5'd1;
      @(negedge clk);
      check("stall_req", wr_req, 1'b1);
      check("stall_busy", fu_busy, 1'b1);
      check("stall_result", result, 16'h0F00);
    end
    issue_valid = 1'b0;
    wr_grant = 1'b1;
    check("stall_grant_result", result, 16'h0F00);
    check("stall_grant_dest", result_dest, 5'd9);
    @(negedge clk);
    check("stall_released", wr_req, 1'b0);
    @(negedge clk);
    check("stall_no_ghost", fu_busy, 1'b0);

    // Back-to-back: issue held across the grant edge is taken one edge later
    wr_grant = 1'b0;
    issue(2'b01, 16'h0001, 16'h0002, 5'd2);
    wait_wr_req();
    check("b2b_first", result, 16'h0003);
    wr_grant    = 1'b1;
    issue_valid = 1'b1;
    issue_op    = 2'b00;
    issue_a     = 16'hF0F0;
    issue_b     = 16'hFF00;
    issue_dest  = 5'd7;
    @(negedge clk);
    check("b2b_grant_edge_busy", fu_busy, 1'b0);
    @(negedge clk);
    issue_valid = 1'b0;
    check("b2b_accept_busy", fu_busy, 1'b1);
    n = 0;
    while (!wr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_latency", n, LATENCY);
    check("b2b_result", result, 16'hF000);
    check("b2b_dest", result_dest, 5'd7);
    wait_idle();

    // Asynchronous reset in the middle of EXEC
    issue(2'b01, 16'd8, 16'd6, 5'd5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", fu_busy, 1'b0);
    check("arst_wr_req", wr_req, 1'b0);
    check("arst_result", result, 16'h0000);
    check("arst_dest", result_dest, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("arst_no_stale_req", wr_req, 1'b0);
    end

    // Three completions after reset
    for (int k = 0; k < 3; k++) begin
      issue(2'b10, 16'(k), 16'hAAAA, 5'(k));
      wait_wr_req();
      check($sformatf("post_rst%0d_result", k), result, 16'hAAAA ^ 16'(k));
      wait_idle();
    end
`ifdef INT_LOGIC_FU_STATS_EN
    check("ops_done_3", ops_done, 16'd3);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
